// File: rtl/sic4_pkg.sv
// Shared types and constants for the SIC-4 execute stage.
// No logic: sequencer state encoding, opcode values, instruction field layout.
// Backpressure: n/a.
package sic4_pkg;

   // Register file geometry; the 2-bit register fields fix the count at 4
   localparam int SIC4_NREGS = 4;
   localparam int SIC4_W     = 8;
   localparam int SIC4_RAW   = 2;

   // Instruction field layout: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
   localparam int FLD_W   = 2;
   localparam int OP_LSB  = 6;
   localparam int RD_LSB  = 4;
   localparam int RS1_LSB = 2;
   localparam int RS2_LSB = 0;

   // ALU opcodes as driven on alu_op
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_SHL = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   // Sequencer states, one instruction passes through all four in order
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   // Decoded view of the latched instruction word
   typedef struct packed {
      logic [FLD_W-1:0] op;
      logic [FLD_W-1:0] rd;
      logic [FLD_W-1:0] rs1;
      logic [FLD_W-1:0] rs2;
   } instr_t;

endpackage

// File: rtl/sic4_regfile.sv
// 4x8 register file: async clear, prioritised write (writeback over external load), three comb reads.
// Latency: write visible on the read ports the cycle after the write edge; reads are combinational.
// Backpressure: none; both write sources are accepted every cycle, writeback wins on an index clash.
module sic4_regfile
   import sic4_pkg::*;
#(
   parameter int NREGS = SIC4_NREGS,
   parameter int W     = SIC4_W,
   parameter int AW    = SIC4_RAW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wb_en,
   input  logic [AW-1:0] i_wb_sel,
   input  logic [W-1:0]  i_wb_data,
   input  logic          i_ld_en,
   input  logic [AW-1:0] i_ld_sel,
   input  logic [W-1:0]  i_ld_data,
   input  logic [AW-1:0] i_rs1_sel,
   input  logic [AW-1:0] i_rs2_sel,
   input  logic [AW-1:0] i_dbg_sel,
   output logic [W-1:0]  o_rs1_data,
   output logic [W-1:0]  o_rs2_data,
   output logic [W-1:0]  o_dbg_data
);

   logic [W-1:0] r_mem [NREGS];

   // Per-register write: writeback has priority, a load to a different index still lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (i_wb_en && (i_wb_sel == AW'(i))) begin
               r_mem[i] <= i_wb_data;
            end else if (i_ld_en && (i_ld_sel == AW'(i))) begin
               r_mem[i] <= i_ld_data;
            end
         end
      end
   end

   // Reads see the pre-edge contents, so a same-cycle load is not forwarded
   assign o_rs1_data = r_mem[i_rs1_sel];
   assign o_rs2_data = r_mem[i_rs2_sel];
   assign o_dbg_data = r_mem[i_dbg_sel];

endmodule

// File: rtl/sic4_exec.sv
// SIC-4 execute sequencer: IDLE->READ->EXEC->WB around an external comb ALU; optional zflag (SIC4_ZFLAG_EN).
// Latency: accept on edge N, operands on N+1, result captured N+2, writeback N+3, next accept N+4.
// Backpressure: instr_ready only in IDLE; instr/instr_valid are ignored while an instruction is in flight.
module sic4_exec
   import sic4_pkg::*;
#(
   parameter int NREGS = SIC4_NREGS,
   parameter int W     = SIC4_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   instr,
   input  logic         instr_valid,
   output logic         instr_ready,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_op,
   input  logic [W-1:0] alu_res,
   input  logic         ld_en,
   input  logic [1:0]   ld_sel,
   input  logic [W-1:0] ld_data,
   input  logic [1:0]   dbg_sel,
   output logic [W-1:0] dbg_data,
   output logic         done
`ifdef SIC4_ZFLAG_EN
   ,
   output logic         zflag
`endif
);

   state_t       r_state;
   instr_t       r_ir;
   logic         r_ready;
   logic         r_done;
   logic [W-1:0] r_alu_a;
   logic [W-1:0] r_alu_b;
   logic [1:0]   r_alu_op;
   logic [W-1:0] r_res_q;

   logic         w_wb_en;
   logic [W-1:0] w_rs1_data;
   logic [W-1:0] w_rs2_data;

   // Writeback commits on the edge that leaves WB
   assign w_wb_en = (r_state == ST_WB);

   sic4_regfile #(
      .NREGS (NREGS),
      .W     (W),
      .AW    (SIC4_RAW)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wb_en    (w_wb_en),
      .i_wb_sel   (r_ir.rd),
      .i_wb_data  (r_res_q),
      .i_ld_en    (ld_en),
      .i_ld_sel   (ld_sel),
      .i_ld_data  (ld_data),
      .i_rs1_sel  (r_ir.rs1),
      .i_rs2_sel  (r_ir.rs2),
      .i_dbg_sel  (dbg_sel),
      .o_rs1_data (w_rs1_data),
      .o_rs2_data (w_rs2_data),
      .o_dbg_data (dbg_data)
   );

   // Sequencer with registered ready/done and operand/result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_ir     <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= OP_ADD;
         r_res_q  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  r_ir    <= instr_t'(instr);
                  r_ready <= 1'b0;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               // Operands are frozen here, so rd aliasing rs1/rs2 cannot disturb them
               r_alu_a  <= w_rs1_data;
               r_alu_b  <= w_rs2_data;
               r_alu_op <= r_ir.op;
               r_state  <= ST_EXEC;
            end
            ST_EXEC: begin
               r_res_q <= alu_res;
               r_done  <= 1'b1;
               r_state <= ST_WB;
            end
            ST_WB: begin
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SIC4_ZFLAG_EN
   logic r_zflag;

   // Zero flag follows the committed result only; external loads leave it alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zflag <= 1'b0;
      end else if (w_wb_en) begin
         r_zflag <= (r_res_q == '0);
      end
   end

   assign zflag = r_zflag;
`endif

   assign instr_ready = r_ready;
   assign done        = r_done;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;

endmodule

// File: tb/tb_sic4_exec.sv
// Self-checking bench for sic4_exec: directed cases plus randomized instructions and loads.
// Register contents predicted by an instruction-level model; the ALU is modelled as a comb block.
// Sampling on the falling edge, inputs driven from the initial block.
module tb_sic4_exec;

   logic       clk;
   logic       rst_n;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_op;
   logic [7:0] alu_res;
   logic       ld_en;
   logic [1:0] ld_sel;
   logic [7:0] ld_data;
   logic [1:0] dbg_sel;
   logic [7:0] dbg_data;
   logic       done;
`ifdef SIC4_ZFLAG_EN
   logic       zflag;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] m [4];

   sic4_exec #(.NREGS(4), .W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_res     (alu_res),
      .ld_en       (ld_en),
      .ld_sel      (ld_sel),
      .ld_data     (ld_data),
      .dbg_sel     (dbg_sel),
      .dbg_data    (dbg_data),
      .done        (done)
`ifdef SIC4_ZFLAG_EN
      ,
      .zflag       (zflag)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External combinational ALU
   always_comb begin
      alu_res = 8'h00;
      case (alu_op)
         2'b00: alu_res = alu_a + alu_b;
         2'b01: alu_res = alu_a - alu_b;
         2'b10: alu_res = alu_b << alu_a;
         2'b11: alu_res = alu_a & alu_b;
         default: alu_res = 8'h00;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // Instruction semantics from the arithmetic rules, modulo 256
   function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (op)
         2'b00: r = (ia + ib) % 256;
         2'b01: r = (ia - ib + 256) % 256;
         2'b10: r = (ia >= 8) ? 0 : ((ib * (1 << ia)) % 256);
         default: r = ia & ib;
      endcase
      return 8'(r);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), {24'h0, dbg_data}, {24'h0, m[i]});
      end
   endtask

   task automatic load(input logic [1:0] sel, input logic [7:0] data);
      ld_en   = 1'b1;
      ld_sel  = sel;
      ld_data = data;
      @(negedge clk);
      ld_en = 1'b0;
      m[sel] = data;
   endtask

   // One instruction end to end; ld_ph 1 = load during READ, 3 = load during WB, 0 = none
   task automatic run(input logic [7:0] ins, input int ld_ph, input logic [1:0] lsel, input logic [7:0] ldat);
      logic [1:0] op, rd, rs1, rs2;
      logic [7:0] a, b, res;
      op  = ins[7:6];
      rd  = ins[5:4];
      rs1 = ins[3:2];
      rs2 = ins[1:0];
      a   = m[rs1];
      b   = m[rs2];
      res = ref_alu(op, a, b);
      chk("ready_idle", {31'h0, instr_ready}, 32'h1);
      instr       = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      // READ: garbage on instr must be ignored
      instr = 8'($urandom);
      if (ld_ph == 1) begin
         ld_en = 1'b1; ld_sel = lsel; ld_data = ldat;
      end
      chk("ready_read", {31'h0, instr_ready}, 32'h0);
      chk("done_read", {31'h0, done}, 32'h0);
      @(negedge clk);
      ld_en = 1'b0;
      // EXEC
      chk("alu_a", {24'h0, alu_a}, {24'h0, a});
      chk("alu_b", {24'h0, alu_b}, {24'h0, b});
      chk("alu_op", {30'h0, alu_op}, {30'h0, op});
      chk("ready_exec", {31'h0, instr_ready}, 32'h0);
      chk("done_exec", {31'h0, done}, 32'h0);
      @(negedge clk);
      instr_valid = 1'b0;
      // WB
      if (ld_ph == 3) begin
         ld_en = 1'b1; ld_sel = lsel; ld_data = ldat;
      end
      chk("done_wb", {31'h0, done}, 32'h1);
      chk("ready_wb", {31'h0, instr_ready}, 32'h0);
      @(negedge clk);
      ld_en = 1'b0;
      if (ld_ph != 0) m[lsel] = ldat;
      m[rd] = res;
      // IDLE again
      chk("done_idle", {31'h0, done}, 32'h0);
      chk("ready_back", {31'h0, instr_ready}, 32'h1);
      chk("alu_a_hold", {24'h0, alu_a}, {24'h0, a});
`ifdef SIC4_ZFLAG_EN
      chk("zflag", {31'h0, zflag}, {31'h0, (res == 8'h00)});
`endif
      check_regs("regs");
   endtask

   logic [7:0] stream_q [$];
   logic [7:0] v;
   int         n_acc;
   int         ph;

   initial begin
      rst_n = 1'b1;
      instr = 8'h00; instr_valid = 1'b0;
      ld_en = 1'b0; ld_sel = 2'd0; ld_data = 8'h00; dbg_sel = 2'd0;
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // Reset state
      chk("rst_ready", {31'h0, instr_ready}, 32'h1);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_alu_a", {24'h0, alu_a}, 32'h0);
      chk("rst_alu_b", {24'h0, alu_b}, 32'h0);
      chk("rst_alu_op", {30'h0, alu_op}, 32'h0);
`ifdef SIC4_ZFLAG_EN
      chk("rst_zflag", {31'h0, zflag}, 32'h0);
`endif
      check_regs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // add r0 = r1 + r2
      load(2'd1, 8'h05);
      load(2'd2, 8'h07);
      run(8'b00_00_01_10, 0, 2'd0, 8'h00);
      chk("add_r0", {24'h0, m[0]}, 32'h0C);
      // sub r3 = r1 - r2 wraps
      run(8'b01_11_01_10, 0, 2'd0, 8'h00);
      // shl r2 = r2 << r1, rd aliases rs2
      load(2'd1, 8'h03);
      load(2'd2, 8'h11);
      run(8'b10_10_01_10, 0, 2'd0, 8'h00);

      // Writeback beats a same-cycle load to rd; a load elsewhere lands
      load(2'd1, 8'h05);
      load(2'd2, 8'h07);
      run(8'b00_00_01_10, 3, 2'd0, 8'hAA);
      run(8'b00_00_01_10, 3, 2'd3, 8'hAA);
      // Load to rs1 during READ: operand takes the old value
      run(8'b00_01_01_10, 1, 2'd1, 8'h40);

      // instr_valid held for 10 cycles: accepts only when ready, every 4 cycles
      n_acc = 0;
      for (int k = 0; k < 10; k++) begin
         v = 8'($urandom);
         instr       = v;
         instr_valid = 1'b1;
         chk($sformatf("stream_ready_%0d", k), {31'h0, instr_ready}, {31'h0, (k % 4 == 0)});
         if (instr_ready) n_acc++;
         if (k % 4 == 0) stream_q.push_back(v);
         @(negedge clk);
      end
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("stream_accepts", n_acc, 3);
      chk("stream_ready_end", {31'h0, instr_ready}, 32'h1);
      while (stream_q.size() > 0) begin
         v = stream_q.pop_front();
         m[v[5:4]] = ref_alu(v[7:6], m[v[3:2]], m[v[1:0]]);
      end
      check_regs("stream");

      // Random instructions with random loads at various points
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 1) == 1) load(2'($urandom), 8'($urandom));
         case ($urandom_range(0, 2))
            0: ph = 0;
            1: ph = 1;
            default: ph = 3;
         endcase
         run(8'($urandom), ph, 2'($urandom), 8'($urandom));
      end

      // Reset while in EXEC: back to IDLE, regs cleared, no done
      load(2'd1, 8'h05);
      load(2'd2, 8'h07);
      instr       = 8'b00_00_01_10;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      @(negedge clk);
      chk("mid_rst_ready", {31'h0, instr_ready}, 32'h1);
      chk("mid_rst_done", {31'h0, done}, 32'h0);
      chk("mid_rst_alu_a", {24'h0, alu_a}, 32'h0);
      check_regs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_done", {31'h0, done}, 32'h0);
      chk("post_rst_ready", {31'h0, instr_ready}, 32'h1);
      // and with zero: r2 = r0 & r1 = 0
      run(8'b11_10_00_01, 0, 2'd0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
